// File: rtl/ddr4_cmd_slot_decoder.sv
// Registered DDR4 instruction-to-DFI slot decoder with a per-bank open/closed tracker.
// Define CMD_2T_EN for 2T timing: the command spans two slots and chip select drops in the second one.
module ddr4_cmd_slot_decoder #(
  parameter int ROW_WIDTH   = 17,
  parameter int BANK_WIDTH  = 2,
  parameter int BG_WIDTH    = 2,
  parameter int CS_WIDTH    = 1,
  parameter int NCK_PER_CLK = 4,
  parameter int CMD_SLOT    = 0
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [31:0]                       instr,
  input  logic                              hold,
  input  logic                              err_clr,
  output logic                              out_valid,
  output logic [ROW_WIDTH*NCK_PER_CLK-1:0]  dfi_address,
  output logic [BANK_WIDTH*NCK_PER_CLK-1:0] dfi_bank,
  output logic [BG_WIDTH*NCK_PER_CLK-1:0]   dfi_bg,
  output logic [CS_WIDTH*NCK_PER_CLK-1:0]   dfi_cs_n,
  output logic [NCK_PER_CLK-1:0]            dfi_act_n,
  output logic [NCK_PER_CLK-1:0]            dfi_ras_n,
  output logic [NCK_PER_CLK-1:0]            dfi_cas_n,
  output logic [NCK_PER_CLK-1:0]            dfi_we_n,
  output logic                              mc_rd_cas,
  output logic                              mc_wr_cas,
  output logic [(1<<(BANK_WIDTH+BG_WIDTH))-1:0] bank_open,
  output logic                              err_act_open,
  output logic                              err_cas_closed,
  output logic                              err_ref_open
);
  localparam int OFS_BANK = ROW_WIDTH;
  localparam int OFS_BG   = OFS_BANK + BANK_WIDTH;
  localparam int OFS_WE   = OFS_BG + BG_WIDTH;
  localparam int OFS_CAS  = OFS_WE + 1;
  localparam int OFS_RAS  = OFS_CAS + 1;
  localparam int OFS_CS   = OFS_RAS + 1;
  localparam int FIELD_W  = OFS_CS + CS_WIDTH;
  localparam int NBANKS   = 1 << (BANK_WIDTH + BG_WIDTH);
`ifdef CMD_2T_EN
  localparam int CMD_SPAN = 2;
`else
  localparam int CMD_SPAN = 1;
`endif
  localparam int CS_SLOT  = CMD_SLOT + CMD_SPAN - 1;

  logic [ROW_WIDTH-1:0]  f_addr;
  logic [BANK_WIDTH-1:0] f_bank;
  logic [BG_WIDTH-1:0]   f_bg;
  logic [CS_WIDTH-1:0]   f_cs_n;
  logic                  f_we, f_cas, f_ras;
  logic                  is_act, is_rd, is_wr, is_pre, is_ref;
  logic [ROW_WIDTH-1:0]  cmd_addr;
  logic [BG_WIDTH+BANK_WIDTH-1:0] idx;

  assign f_addr = instr[OFS_BANK-1:0];
  assign f_bank = instr[OFS_BG-1:OFS_BANK];
  assign f_bg   = instr[OFS_WE-1:OFS_BG];
  assign f_we   = instr[OFS_WE];
  assign f_cas  = instr[OFS_CAS];
  assign f_ras  = instr[OFS_RAS];
  assign f_cs_n = instr[FIELD_W-1:OFS_CS];
  assign idx    = {f_bg, f_bank};

  generate
    if (FIELD_W < 32) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^instr[31:FIELD_W];
    end
  endgenerate

  assign is_act = ~f_ras &  f_cas &  f_we;
  assign is_rd  =  f_ras & ~f_cas &  f_we;
  assign is_wr  =  f_ras & ~f_cas & ~f_we;
  assign is_pre = ~f_ras &  f_cas & ~f_we;
  assign is_ref = ~f_ras & ~f_cas &  f_we;

  // ACT drives the full row; every other command reuses A16:A14 as RAS/CAS/WE.
  assign cmd_addr = is_act ? f_addr : {f_ras, f_cas, f_we, f_addr[ROW_WIDTH-4:0]};

  assign in_ready = ~hold;

  logic [NCK_PER_CLK-1:0][ROW_WIDTH-1:0]  addr_q, addr_d;
  logic [NCK_PER_CLK-1:0][BANK_WIDTH-1:0] bank_q, bank_d;
  logic [NCK_PER_CLK-1:0][BG_WIDTH-1:0]   bg_q, bg_d;
  logic [NCK_PER_CLK-1:0][CS_WIDTH-1:0]   cs_n_q, cs_n_d;
  logic [NCK_PER_CLK-1:0] act_n_q, act_n_d, ras_n_q, ras_n_d, cas_n_q, cas_n_d, we_n_q, we_n_d;
  logic out_valid_q, out_valid_d, rd_cas_q, rd_cas_d, wr_cas_q, wr_cas_d;
  logic [NBANKS-1:0] open_q, open_d;
  logic eao_q, eao_d, ecc_q, ecc_d, ero_q, ero_d;

  always_comb begin
    addr_d = addr_q;  bank_d = bank_q;  bg_d = bg_q;  cs_n_d = cs_n_q;
    act_n_d = act_n_q;  ras_n_d = ras_n_q;  cas_n_d = cas_n_q;  we_n_d = we_n_q;
    out_valid_d = out_valid_q;  rd_cas_d = rd_cas_q;  wr_cas_d = wr_cas_q;
    if (!hold) begin
      addr_d = '0;  bank_d = '0;  bg_d = '0;  cs_n_d = '1;
      act_n_d = '1;  ras_n_d = '1;  cas_n_d = '1;  we_n_d = '1;
      out_valid_d = in_valid;
      rd_cas_d    = in_valid & is_rd;
      wr_cas_d    = in_valid & is_wr;
      if (in_valid) begin
        for (int k = 0; k < CMD_SPAN; k++) begin
          addr_d[CMD_SLOT+k]  = cmd_addr;
          bank_d[CMD_SLOT+k]  = f_bank;
          bg_d[CMD_SLOT+k]    = f_bg;
          act_n_d[CMD_SLOT+k] = ~is_act;
          ras_n_d[CMD_SLOT+k] = f_ras;
          cas_n_d[CMD_SLOT+k] = f_cas;
          we_n_d[CMD_SLOT+k]  = f_we;
        end
        cs_n_d[CS_SLOT] = f_cs_n;
      end
    end
  end

  // Illegal sequences are only flagged; the command itself is always forwarded.
  always_comb begin
    open_d = open_q;  eao_d = eao_q;  ecc_d = ecc_q;  ero_d = ero_q;
    if (!hold) begin
      eao_d = eao_q & ~err_clr;
      ecc_d = ecc_q & ~err_clr;
      ero_d = ero_q & ~err_clr;
      if (in_valid && !f_cs_n[0]) begin
        if (is_act) begin
          if (open_q[idx]) eao_d = 1'b1;
          open_d[idx] = 1'b1;
        end
        if (is_pre) begin
          if (f_addr[10]) open_d = '0;
          else            open_d[idx] = 1'b0;
        end
        if ((is_rd || is_wr) && !open_q[idx]) ecc_d = 1'b1;
        if (is_ref && (|open_q)) ero_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;  bank_q <= '0;  bg_q <= '0;  cs_n_q <= '1;
      act_n_q <= '1;  ras_n_q <= '1;  cas_n_q <= '1;  we_n_q <= '1;
      out_valid_q <= 1'b0;  rd_cas_q <= 1'b0;  wr_cas_q <= 1'b0;
      open_q <= '0;  eao_q <= 1'b0;  ecc_q <= 1'b0;  ero_q <= 1'b0;
    end else begin
      addr_q <= addr_d;  bank_q <= bank_d;  bg_q <= bg_d;  cs_n_q <= cs_n_d;
      act_n_q <= act_n_d;  ras_n_q <= ras_n_d;  cas_n_q <= cas_n_d;  we_n_q <= we_n_d;
      out_valid_q <= out_valid_d;  rd_cas_q <= rd_cas_d;  wr_cas_q <= wr_cas_d;
      open_q <= open_d;  eao_q <= eao_d;  ecc_q <= ecc_d;  ero_q <= ero_d;
    end
  end

  // Slot-major registers flattened into the bit-major DFI layout.
  generate
    for (genvar s = 0; s < NCK_PER_CLK; s++) begin : g_slot
      for (genvar b = 0; b < ROW_WIDTH; b++) begin : g_a
        assign dfi_address[b*NCK_PER_CLK+s] = addr_q[s][b];
      end
      for (genvar b = 0; b < BANK_WIDTH; b++) begin : g_b
        assign dfi_bank[b*NCK_PER_CLK+s] = bank_q[s][b];
      end
      for (genvar b = 0; b < BG_WIDTH; b++) begin : g_g
        assign dfi_bg[b*NCK_PER_CLK+s] = bg_q[s][b];
      end
      for (genvar b = 0; b < CS_WIDTH; b++) begin : g_c
        assign dfi_cs_n[b*NCK_PER_CLK+s] = cs_n_q[s][b];
      end
    end
  endgenerate

  assign dfi_act_n      = act_n_q;
  assign dfi_ras_n      = ras_n_q;
  assign dfi_cas_n      = cas_n_q;
  assign dfi_we_n       = we_n_q;
  assign out_valid      = out_valid_q;
  assign mc_rd_cas      = rd_cas_q;
  assign mc_wr_cas      = wr_cas_q;
  assign bank_open      = open_q;
  assign err_act_open   = eao_q;
  assign err_cas_closed = ecc_q;
  assign err_ref_open   = ero_q;
endmodule

// File: tb/tb_ddr4_cmd_slot_decoder.sv
// Randomised bench for ddr4_cmd_slot_decoder with an instruction-level reference model.
module tb_ddr4_cmd_slot_decoder;
  localparam int RW = 17, BW = 2, GW = 2, CW = 1, N = 4, CS = 0;
  localparam int NB = 16;
  localparam int C_ACT = 3, C_RD = 5, C_WR = 4, C_PRE = 2, C_REF = 1;

  logic clk = 1'b0, rst_n = 1'b0;
  logic in_valid = 1'b0, hold = 1'b0, err_clr = 1'b0;
  logic [31:0] instr = '0;
  logic in_ready, out_valid, mc_rd_cas, mc_wr_cas;
  logic [RW*N-1:0] dfi_address;
  logic [BW*N-1:0] dfi_bank;
  logic [GW*N-1:0] dfi_bg;
  logic [CW*N-1:0] dfi_cs_n;
  logic [N-1:0] dfi_act_n, dfi_ras_n, dfi_cas_n, dfi_we_n;
  logic [NB-1:0] bank_open;
  logic err_act_open, err_cas_closed, err_ref_open;

  ddr4_cmd_slot_decoder #(.ROW_WIDTH(RW), .BANK_WIDTH(BW), .BG_WIDTH(GW), .CS_WIDTH(CW),
                          .NCK_PER_CLK(N), .CMD_SLOT(CS)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .instr(instr),
    .hold(hold), .err_clr(err_clr), .out_valid(out_valid), .dfi_address(dfi_address),
    .dfi_bank(dfi_bank), .dfi_bg(dfi_bg), .dfi_cs_n(dfi_cs_n), .dfi_act_n(dfi_act_n),
    .dfi_ras_n(dfi_ras_n), .dfi_cas_n(dfi_cas_n), .dfi_we_n(dfi_we_n),
    .mc_rd_cas(mc_rd_cas), .mc_wr_cas(mc_wr_cas), .bank_open(bank_open),
    .err_act_open(err_act_open), .err_cas_closed(err_cas_closed), .err_ref_open(err_ref_open));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  // Model: what each slot must show, plus the bank/error state.
  int unsigned e_addr[N], e_bank[N], e_bg[N], e_cs[N], e_act[N], e_ras[N], e_cas[N], e_we[N];
  int unsigned e_valid, e_rd, e_wr, e_eao, e_ecc, e_ero;
  logic [NB-1:0] e_open;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int unsigned pick(input logic [127:0] v, input int w, input int s);
    int unsigned r = 0;
    for (int b = 0; b < w; b++) r |= 32'(v[b*N+s]) << b;
    return r;
  endfunction

  function automatic logic [31:0] mk(input int r, input int c, input int w, input int bg,
                                     input int bk, input int a, input int csn);
    return 32'(a) | 32'(bk << 17) | 32'(bg << 19) | 32'(w << 21) | 32'(c << 22) |
           32'(r << 23) | 32'(csn << 24);
  endfunction

  task automatic idle_slots();
    for (int s = 0; s < N; s++) begin
      e_addr[s] = 0; e_bank[s] = 0; e_bg[s] = 0; e_cs[s] = 1;
      e_act[s] = 1; e_ras[s] = 1; e_cas[s] = 1; e_we[s] = 1;
    end
  endtask

  task automatic model_reset();
    idle_slots();
    e_valid = 0; e_rd = 0; e_wr = 0; e_eao = 0; e_ecc = 0; e_ero = 0; e_open = '0;
  endtask

  task automatic model_step();
    int unsigned a, bk, bg, csn, r, c, w, cmd, ix;
    if (hold) return;
    if (err_clr) begin e_eao = 0; e_ecc = 0; e_ero = 0; end
    idle_slots();
    e_valid = 32'(in_valid); e_rd = 0; e_wr = 0;
    if (!in_valid) return;
    a = instr & 32'h1FFFF;  bk = (instr >> 17) & 3;  bg = (instr >> 19) & 3;
    w = (instr >> 21) & 1;  c = (instr >> 22) & 1;  r = (instr >> 23) & 1;
    csn = (instr >> 24) & 1;
    cmd = r * 4 + c * 2 + w;
    e_cs[CS] = csn; e_ras[CS] = r; e_cas[CS] = c; e_we[CS] = w;
    e_bank[CS] = bk; e_bg[CS] = bg;
    e_act[CS] = (cmd == C_ACT) ? 0 : 1;
    e_addr[CS] = (cmd == C_ACT) ? a : (r << 16) + (c << 15) + (w << 14) + (a % 16384);
    e_rd = 32'(cmd == C_RD); e_wr = 32'(cmd == C_WR);
    if (csn == 0) begin
      ix = bg * 4 + bk;
      case (cmd)
        C_ACT: begin if (e_open[ix]) e_eao = 1; e_open[ix] = 1'b1; end
        C_PRE: if (((a >> 10) & 1) == 1) e_open = '0; else e_open[ix] = 1'b0;
        C_RD, C_WR: if (!e_open[ix]) e_ecc = 1;
        C_REF: if (e_open != '0) e_ero = 1;
        default: ;
      endcase
    end
  endtask

  task automatic cyc(input logic v, input logic [31:0] ins, input logic h, input logic c);
    in_valid = v; instr = ins; hold = h; err_clr = c;
    @(posedge clk);
    if (rst_n) model_step(); else model_reset();
    #1;
  endtask

  // Single compare process: every cycle the registered outputs must match the model.
  always @(negedge clk) begin
    for (int s = 0; s < N; s++) begin
      chk($sformatf("addr[%0d]", s), pick(128'(dfi_address), RW, s), e_addr[s]);
      chk($sformatf("bank[%0d]", s), pick(128'(dfi_bank), BW, s), e_bank[s]);
      chk($sformatf("bg[%0d]", s),   pick(128'(dfi_bg), GW, s), e_bg[s]);
      chk($sformatf("cs_n[%0d]", s), pick(128'(dfi_cs_n), CW, s), e_cs[s]);
      chk($sformatf("act_n[%0d]", s), dfi_act_n[s], e_act[s]);
      chk($sformatf("ras_n[%0d]", s), dfi_ras_n[s], e_ras[s]);
      chk($sformatf("cas_n[%0d]", s), dfi_cas_n[s], e_cas[s]);
      chk($sformatf("we_n[%0d]", s),  dfi_we_n[s], e_we[s]);
    end
    chk("out_valid", out_valid, e_valid);
    chk("mc_rd_cas", mc_rd_cas, e_rd);
    chk("mc_wr_cas", mc_wr_cas, e_wr);
    chk("bank_open", bank_open, e_open);
    chk("err_act_open", err_act_open, e_eao);
    chk("err_cas_closed", err_cas_closed, e_ecc);
    chk("err_ref_open", err_ref_open, e_ero);
    chk("in_ready", in_ready, !hold);
  end

  initial begin
    logic [31:0] ins;
    int k;
    model_reset();
    cyc(0, '0, 0, 0);
    cyc(0, '0, 0, 0);
    rst_n = 1'b1;
    cyc(0, '0, 0, 0);
    chk("lit_rst_cs_n", dfi_cs_n, 4'hF);
    chk("lit_rst_act_n", dfi_act_n, 4'hF);
    chk("lit_rst_addr", dfi_address, 0);
    chk("lit_rst_valid", out_valid, 0);
    chk("lit_rst_open", bank_open, 0);

    cyc(1, mk(0, 1, 1, 1, 2, 'h1ABCD, 0), 0, 0);          // ACT bg1 bank2
    chk("lit_act_act_n", dfi_act_n, 4'b1110);
    chk("lit_act_addr0", pick(128'(dfi_address), RW, 0), 'h1ABCD);
    chk("lit_act_addr1", pick(128'(dfi_address), RW, 1), 0);
    chk("lit_act_addr3", pick(128'(dfi_address), RW, 3), 0);
    chk("lit_act_open", bank_open, 16'h0040);
    chk("lit_act_valid", out_valid, 1);

    cyc(1, mk(1, 0, 1, 1, 2, 'h0010, 0), 0, 0);           // READ to open bank
    chk("lit_rd_addr0", pick(128'(dfi_address), RW, 0), 'h14010);
    chk("lit_rd_act_n", dfi_act_n, 4'b1111);
    chk("lit_rd_cas", mc_rd_cas, 1);
    chk("lit_rd_errs", {err_act_open, err_cas_closed, err_ref_open}, 0);

    cyc(1, mk(1, 0, 0, 0, 0, 'h0020, 0), 0, 0);           // WRITE to closed bank
    chk("lit_wr_ecc", err_cas_closed, 1);
    chk("lit_wr_cs_n", dfi_cs_n, 4'b1110);
    chk("lit_wr_cas", mc_wr_cas, 1);
    cyc(0, '0, 0, 1);
    chk("lit_clr_ecc", err_cas_closed, 0);
    cyc(1, mk(0, 1, 1, 1, 2, 'h00001, 0), 0, 0);          // ACT to already-open bank
    chk("lit_eao", err_act_open, 1);

    cyc(1, mk(0, 1, 0, 0, 0, 'h00400, 0), 0, 0);          // PRE all
    chk("lit_pre_all", bank_open, 0);
    cyc(1, mk(0, 0, 1, 0, 0, 0, 0), 0, 0);                // REF, all closed
    chk("lit_ref_ok", err_ref_open, 0);
    cyc(1, mk(0, 1, 1, 0, 3, 'h00123, 0), 0, 0);          // ACT bank3
    cyc(1, mk(0, 0, 1, 0, 0, 0, 0), 0, 0);                // REF with bank open
    chk("lit_ref_err", err_ref_open, 1);

    for (int i = 0; i < 3; i++) begin
      cyc(1, mk(0, 1, 1, 2, 1, 'h0ABCD, 0), 1, 1);
      chk("lit_hold_ready", in_ready, 0);
      chk("lit_hold_addr", pick(128'(dfi_address), RW, 0), 'h04000);
      chk("lit_hold_ras", dfi_ras_n, 4'b1110);
      chk("lit_hold_ero", err_ref_open, 1);
    end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("lit_arst_valid", out_valid, 0);
    chk("lit_arst_cs_n", dfi_cs_n, 4'hF);
    chk("lit_arst_act_n", dfi_act_n, 4'hF);
    chk("lit_arst_open", bank_open, 0);
    cyc(1, mk(0, 1, 1, 0, 0, 0, 0), 1, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 600; i++) begin
      k = $urandom_range(0, 9);
      case (k)
        0, 1, 2: ins = mk(0, 1, 1, 0, 0, 0, 0);
        3:       ins = mk(1, 0, 1, 0, 0, 0, 0);
        4:       ins = mk(1, 0, 0, 0, 0, 0, 0);
        5:       ins = mk(0, 1, 0, 0, 0, 0, 0);
        6:       ins = mk(0, 0, 1, 0, 0, 0, 0);
        7:       ins = mk(0, 0, 0, 0, 0, 0, 0);
        8:       ins = mk(1, 1, 0, 0, 0, 0, 0);
        default: ins = mk(1, 1, 1, 0, 0, 0, 0);
      endcase
      ins |= mk(0, 0, 0, $urandom_range(0, 3), $urandom_range(0, 3),
                $urandom_range(0, 'h1FFFF), ($urandom_range(0, 7) == 0) ? 1 : 0);
      ins |= $urandom & 32'hFE00_0000;
      if (i == 300) begin
        #2; rst_n = 1'b0; model_reset(); #1;
        chk("lit_arst2_valid", out_valid, 0);
        cyc(0, '0, 0, 0);
        rst_n = 1'b1;
      end
      cyc($urandom_range(0, 9) < 8, ins, $urandom_range(0, 99) < 15, $urandom_range(0, 9) == 0);
    end
    cyc(0, '0, 0, 0);
    @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
